// File: rtl/regfile_scanout.sv
// Halt-time register file dump: walks r0..r(SIZE-1) through one read port and
// streams {index, value} beats over valid/ready while accumulating a checksum.
module regfile_scanout #(
    parameter int XLEN = 32,
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halted,
    output logic [4:0]      rd_num,
    input  logic [XLEN-1:0] rd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_idx,
    output logic [XLEN-1:0] out_data,
    output logic            out_last,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] out_sum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(SIZE - 1);

    state_t     state;
    state_t     state_nxt;
    logic       halted_q;
    logic       start;
    logic [4:0] idx;

    assign start  = halted & ~halted_q;
    // Address comes only from the registered index, never from rd_data.
    assign rd_num = idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                busy      = 1'b1;
                state_nxt = S_SEND;
            end
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = out_last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!halted) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
            idx      <= '0;
            out_sum  <= '0;
            out_idx  <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            halted_q <= halted;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        out_sum <= '0;
                    end
                end
                S_READ: begin
                    out_data <= rd_data;
                    out_idx  <= idx;
                    out_last <= (idx == LAST_IDX);
                end
                S_SEND: begin
                    // Payload registers are untouched here, so a stalled beat stays stable.
                    if (out_ready) begin
                        out_sum <= out_sum + out_data;
                        if (!out_last) begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
